// File: rtl/lcd_de_receiver.sv
// ---------------------------------------------------------------------------
// lcd_de_receiver
//
// Receive end of a DE-mode parallel RGB interface (HS/VS unused). Frame and
// line structure is recovered from data-enable alone: a long run of DE-low
// cycles (VGAP_MIN) marks vertical blanking, any shorter run is a line gap.
// Pixel coordinates are regenerated, per-line length errors are flagged and
// the active size of each completed frame is reported.
//
// Ports
//   clk        pixel clock
//   rstn       asynchronous active-low reset
//   de_in      data enable
//   rgb_in     pixel data, qualified by de_in
//   pix_valid  pix_data/pix_x/pix_y valid this cycle
//   pix_data   received pixel
//   pix_x      0-based column (saturates at 2^CW-1)
//   pix_y      0-based line   (saturates at 2^CW-1)
//   sof        pulse on pixel (0,0) of a frame
//   eol        pulse on the last pixel of each line
//   err_line   pulse with eol when the line length is wrong or overflowed
//   frame_w    width of line 0 of the last completed frame
//   frame_h    line count of the last completed frame (saturates at 2^CW)
//   locked     last completed frame was EXP_H x EXP_V with no bad line
//
// Pipeline: stage 1 registers de_in/rgb_in; stage 2 registers the outputs.
// Output latency is two clocks from the input sample.
// ---------------------------------------------------------------------------
module lcd_de_receiver #(
    parameter int DATA_W   = 24,
    parameter int CW       = 10,
    parameter int EXP_H    = 800,
    parameter int EXP_V    = 480,
    parameter int VGAP_MIN = 2000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              de_in,
    input  logic [DATA_W-1:0] rgb_in,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [CW-1:0]     pix_x,
    output logic [CW-1:0]     pix_y,
    output logic              sof,
    output logic              eol,
    output logic              err_line,
    output logic [CW:0]       frame_w,
    output logic [CW:0]       frame_h,
    output logic              locked
);

    localparam logic [CW-1:0] X_MAX    = {CW{1'b1}};
    localparam logic [CW:0]   LEN_OVF  = {1'b1, {CW{1'b0}}};
    localparam logic [15:0]   GAP_MAX  = 16'(VGAP_MIN);
    localparam logic [CW:0]   EXP_H_W  = (CW+1)'(EXP_H);
    localparam logic [CW:0]   EXP_V_W  = (CW+1)'(EXP_V);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Saturating increment for coordinate counters.
    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == X_MAX) begin
            r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    // Saturating increment for the line counter, capped at 2^CW.
    function automatic logic [CW:0] sat_inc_len(input logic [CW:0] v);
        logic [CW:0] r;
        if (v == LEN_OVF) begin
            r = v;
        end else begin
            r = v + (CW+1)'(1);
        end
        return r;
    endfunction

    // stage 1 and gap tracking
    logic              de1_r;
    logic              de1_d_r;
    logic [DATA_W-1:0] rgb1_r;
    logic [15:0]       gap_cnt_r;

    // FSM
    state_t            state_r;
    state_t            state_nxt_s;

    // stage 2 / frame tracking
    logic              pix_valid_r;
    logic [DATA_W-1:0] pix_data_r;
    logic [CW-1:0]     pix_x_r;
    logic [CW-1:0]     pix_y_r;
    logic              sof_r;
    logic              eol_r;
    logic              err_line_r;
    logic              x_ovf_r;
    logic [CW:0]       line_cnt_r;
    logic [CW:0]       ref_w_r;
    logic              frame_err_r;
    logic [CW:0]       frame_w_r;
    logic [CW:0]       frame_h_r;
    logic              locked_r;

    // combinational next values
    logic              rise_s;
    logic              vgap_s;
    logic              valid_nxt_s;
    logic              sof_nxt_s;
    logic [CW-1:0]     x_nxt_s;
    logic [CW-1:0]     y_nxt_s;
    logic              ovf_nxt_s;
    logic [CW:0]       line_nxt_s;
    logic              frame_end_s;
    logic              eol_nxt_s;
    logic              err_nxt_s;
    logic              first_line_s;
    logic [CW:0]       len_s;

    assign rise_s = de1_r & ~de1_d_r;
    assign vgap_s = (gap_cnt_r == GAP_MAX);

    // Stage-1 capture and DE-low run counter (aligned with the stage-1 sample).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de1_r     <= 1'b0;
            de1_d_r   <= 1'b0;
            rgb1_r    <= {DATA_W{1'b0}};
            gap_cnt_r <= 16'd0;
        end else begin
            de1_r   <= de_in;
            de1_d_r <= de1_r;
            rgb1_r  <= rgb_in;
            if (de_in) begin
                gap_cnt_r <= 16'd0;
            end else if (gap_cnt_r != GAP_MAX) begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: vertical gap arms the receiver, a DE rise opens a frame.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (vgap_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_ARMED: begin
                if (rise_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_ACTIVE: begin
                if (vgap_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
            end
        endcase
    end

    // FSM outputs: coordinate generation for the pixel currently in stage 1.
    always_comb begin
        valid_nxt_s = 1'b0;
        sof_nxt_s   = 1'b0;
        x_nxt_s     = pix_x_r;
        y_nxt_s     = pix_y_r;
        ovf_nxt_s   = x_ovf_r;
        line_nxt_s  = line_cnt_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_ARMED: begin
                if (rise_s) begin
                    valid_nxt_s = 1'b1;
                    sof_nxt_s   = 1'b1;
                    x_nxt_s     = {CW{1'b0}};
                    y_nxt_s     = {CW{1'b0}};
                    ovf_nxt_s   = 1'b0;
                    line_nxt_s  = (CW+1)'(1);
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (de1_r) begin
                    valid_nxt_s = 1'b1;
                    if (rise_s) begin
                        x_nxt_s    = {CW{1'b0}};
                        ovf_nxt_s  = 1'b0;
                        y_nxt_s    = sat_inc_cw(pix_y_r);
                        line_nxt_s = sat_inc_len(line_cnt_r);
                    end else if (pix_x_r == X_MAX) begin
                        // column counter pinned; remember the line overflowed
                        ovf_nxt_s = 1'b1;
                    end else begin
                        x_nxt_s = pix_x_r + CW'(1);
                    end
                end else if (vgap_s) begin
                    frame_end_s = 1'b1;
                end else begin
                    frame_end_s = 1'b0;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Line-end detection and length check; de_in is the successor of stage 1.
    always_comb begin
        eol_nxt_s    = valid_nxt_s & ~de_in;
        first_line_s = (y_nxt_s == {CW{1'b0}});
        if (ovf_nxt_s) begin
            len_s = LEN_OVF;
        end else begin
            len_s = {1'b0, x_nxt_s} + (CW+1)'(1);
        end
        err_nxt_s = eol_nxt_s & (ovf_nxt_s | (~first_line_s & (len_s != ref_w_r)));
    end

    // Stage-2 output registers and per-frame statistics.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= {DATA_W{1'b0}};
            pix_x_r     <= {CW{1'b0}};
            pix_y_r     <= {CW{1'b0}};
            sof_r       <= 1'b0;
            eol_r       <= 1'b0;
            err_line_r  <= 1'b0;
            x_ovf_r     <= 1'b0;
            line_cnt_r  <= {(CW+1){1'b0}};
            ref_w_r     <= {(CW+1){1'b0}};
            frame_err_r <= 1'b0;
            frame_w_r   <= {(CW+1){1'b0}};
            frame_h_r   <= {(CW+1){1'b0}};
            locked_r    <= 1'b0;
        end else begin
            pix_valid_r <= valid_nxt_s;
            sof_r       <= sof_nxt_s;
            eol_r       <= eol_nxt_s;
            err_line_r  <= err_nxt_s;
            pix_x_r     <= x_nxt_s;
            pix_y_r     <= y_nxt_s;
            x_ovf_r     <= ovf_nxt_s;
            line_cnt_r  <= line_nxt_s;
            if (valid_nxt_s) begin
                pix_data_r <= rgb1_r;
            end
            if (eol_nxt_s && first_line_s) begin
                ref_w_r <= len_s;
            end
            if (sof_nxt_s) begin
                frame_err_r <= err_nxt_s;
            end else if (err_nxt_s) begin
                frame_err_r <= 1'b1;
            end
            if (frame_end_s) begin
                frame_w_r <= ref_w_r;
                frame_h_r <= line_cnt_r;
                locked_r  <= (ref_w_r == EXP_H_W) && (line_cnt_r == EXP_V_W) && !frame_err_r;
            end
        end
    end

    assign pix_valid = pix_valid_r;
    assign pix_data  = pix_data_r;
    assign pix_x     = pix_x_r;
    assign pix_y     = pix_y_r;
    assign sof       = sof_r;
    assign eol       = eol_r;
    assign err_line  = err_line_r;
    assign frame_w   = frame_w_r;
    assign frame_h   = frame_h_r;
    assign locked    = locked_r;

endmodule

// File: tb/tb_lcd_de_receiver.sv
// ---------------------------------------------------------------------------
// tb_lcd_de_receiver
//
// Stimulus is built from gaps and lines. A stream-level model decides, per
// driven pixel, what the receiver must present and pushes it into a queue;
// an independent monitor pops and compares whenever pix_valid is high.
// Frame statistics are compared at the end of each long blanking gap.
// ---------------------------------------------------------------------------
module tb_lcd_de_receiver;

    localparam int DW   = 24;
    localparam int CW   = 10;
    localparam int EH   = 8;
    localparam int EV   = 4;
    localparam int VG   = 20;
    localparam int XMAX = 1023;
    localparam int LMAX = 1024;
    localparam int LAT  = 24;   // push time to monitor sample, in ns

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          de_in  = 1'b0;
    logic [DW-1:0] rgb_in = 24'd0;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          sof;
    logic          eol;
    logic          err_line;
    logic [CW:0]   frame_w;
    logic [CW:0]   frame_h;
    logic          locked;

    lcd_de_receiver #(
        .DATA_W  (DW),
        .CW      (CW),
        .EXP_H   (EH),
        .EXP_V   (EV),
        .VGAP_MIN(VG)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .de_in    (de_in),
        .rgb_in   (rgb_in),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .sof      (sof),
        .eol      (eol),
        .err_line (err_line),
        .frame_w  (frame_w),
        .frame_h  (frame_h),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            x;
        int            y;
        bit            sof;
        bit            eol;
        bit            err;
        longint        t;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    // stream-level model state: 0 searching, 1 armed, 2 inside a frame
    int m_state = 0;
    int lowrun  = 0;
    int m_line  = 0;
    int m_ref   = 0;
    bit m_ferr  = 1'b0;
    int m_fw    = 0;
    int m_fh    = 0;
    bit m_lock  = 1'b0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act == req) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic cyc(bit d, logic [DW-1:0] v);
        de_in  = d;
        rgb_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_sof", int'(sof), 0);
        check("rst_eol", int'(eol), 0);
        check("rst_err_line", int'(err_line), 0);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_frame_w", int'(frame_w), 0);
        check("rst_frame_h", int'(frame_h), 0);
        check("rst_locked", int'(locked), 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        m_state = 0;
        lowrun  = 0;
        m_fw    = 0;
        m_fh    = 0;
        m_lock  = 1'b0;
    endtask

    task automatic finalize_frame();
        m_fw   = m_ref;
        m_fh   = (m_line > LMAX) ? LMAX : m_line;
        m_lock = (m_fw == EH) && (m_fh == EV) && !m_ferr;
    endtask

    task automatic drive_gap(int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 24'($urandom));
            lowrun++;
            if (lowrun == VG) begin
                if (m_state == 2) finalize_frame();
                m_state = 1;
            end
        end
        if (lowrun >= VG + 2) begin
            check("frame_w", int'(frame_w), m_fw);
            check("frame_h", int'(frame_h), m_fh);
            check("locked", int'(locked), int'(m_lock));
        end
    endtask

    // rst_at >= 0 pulses reset just before that pixel index is driven
    task automatic drive_line(int len, bit pat, int rst_at);
        int            li;
        int            rep;
        bit            act;
        exp_t          e;
        logic [DW-1:0] d;
        li  = 0;
        rep = (len > LMAX) ? LMAX : len;
        if (m_state == 1) begin
            m_state = 2;
            m_line  = 0;
            m_ferr  = 1'b0;
        end
        act = (m_state == 2);
        if (act) begin
            li = m_line;
            m_line++;
            if (li == 0) m_ref = rep;
        end
        lowrun = 0;
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                do_reset();
                act = 1'b0;
            end
            d = pat ? {12'(li), 12'(i)} : 24'($urandom);
            if (act) begin
                e.d   = d;
                e.x   = (i > XMAX) ? XMAX : i;
                e.y   = (li > XMAX) ? XMAX : li;
                e.sof = (li == 0) && (i == 0);
                e.eol = (i == len - 1);
                e.err = e.eol && ((len > LMAX) || (li != 0 && rep != m_ref));
                if (e.err) m_ferr = 1'b1;
                e.t   = $time;
                exp_q.push_back(e);
            end
            cyc(1'b1, d);
        end
        lowrun = 0;
    endtask

    task automatic drive_frame(int nl, int len, int bad_line, int bad_len, int hb);
        for (int l = 0; l < nl; l++) begin
            drive_line((l == bad_line) ? bad_len : len, 1'b1, -1);
            if (l < nl - 1) drive_gap(hb);
        end
    endtask

    // Monitor: every presented pixel must match the head of the queue.
    always @(negedge clk) begin
        if (rstn && pix_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pix_data", int'(pix_data), int'(e.d));
                check("pix_x", int'(pix_x), e.x);
                check("pix_y", int'(pix_y), e.y);
                check("sof", int'(sof), int'(e.sof));
                check("eol", int'(eol), int'(e.eol));
                check("err_line", int'(err_line), int'(e.err));
                check("latency", int'($time - e.t), LAT);
            end
        end else if (rstn && (sof || eol || err_line)) begin
            check("strobe_without_valid", 1, 0);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // clean frame with leading blanking
        drive_gap(30);
        drive_frame(4, 8, -1, 8, 5);
        drive_gap(30);

        // no leading blanking: first frame ignored, second one locks
        do_reset();
        drive_frame(4, 8, -1, 8, 5);
        drive_gap(30);
        drive_frame(4, 8, -1, 8, 5);
        drive_gap(30);

        // one long line breaks lock, next clean frame restores it
        drive_frame(4, 8, 2, 9, 5);
        drive_gap(30);
        drive_frame(4, 8, -1, 8, 5);
        drive_gap(30);

        // 19-cycle gaps are line gaps: one 8-line frame
        drive_frame(8, 8, -1, 8, 19);
        drive_gap(30);

        // reset in the middle of line 2
        drive_line(8, 1'b1, -1);
        drive_gap(5);
        drive_line(8, 1'b1, -1);
        drive_gap(5);
        drive_line(8, 1'b1, 3);
        drive_gap(5);
        drive_line(8, 1'b1, -1);
        drive_gap(30);
        drive_frame(4, 8, -1, 8, 5);
        drive_gap(30);

        // single-pixel first line, then an overlong line
        drive_line(1, 1'b1, -1);
        drive_gap(5);
        drive_line(1030, 1'b1, -1);
        drive_gap(30);
        // overlong first line
        drive_line(1030, 1'b1, -1);
        drive_gap(5);
        drive_line(8, 1'b1, -1);
        drive_gap(30);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int nl;
            nl = $urandom_range(5, 3);
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(4, 0) == 0) ? $urandom_range(9, 7) : 8;
                drive_line(len, 1'b0, -1);
                if (l < nl - 1) drive_gap($urandom_range(19, 1));
            end
            drive_gap($urandom_range(40, 22));
        end

        drive_gap(5);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lcd_de_receiver.md
Name: lcd_de_receiver

Overview:
- Receive end of the parallel DE-mode LCD/RGB interface that vga_ctrl drives: 24-bit RGB plus data-enable, with HS/VS tied high.
- Recovers frame and line structure from DE alone, regenerates pixel coordinates, and flags timing errors.
- Measures active width and height of each frame.
- Used for loopback checking of the display path and as the front end of any future video-capture path.

Parameters:
- DATA_W, 24, pixel data width (R[23:16], G[15:8], B[7:0]).
- CW, 10, coordinate counter width (pix_x/pix_y).
- EXP_H, 800, expected active pixels per line; used for lock.
- EXP_V, 480, expected active lines per frame; used for lock.
- VGAP_MIN, 2000, minimum consecutive DE-low cycles that count as vertical blanking. Must exceed the horizontal blank and be less than 65535.

Ports:
- clk, input, 1, pixel clock (same clock as LCD_PCLK).
- rstn, input, 1, asynchronous active-low reset.
- de_in, input, 1, data enable from the interface.
- rgb_in, input, DATA_W, pixel data, qualified by de_in.
- pix_valid, output, 1, pix_data/pix_x/pix_y are valid this cycle.
- pix_data, output, DATA_W, received pixel.
- pix_x, output, CW, column of the current pixel, 0-based.
- pix_y, output, CW, line of the current pixel, 0-based.
- sof, output, 1, one-cycle pulse on pixel (0,0) of a frame.
- eol, output, 1, one-cycle pulse on the last pixel of each line.
- err_line, output, 1, one-cycle pulse, coincident with eol, on a bad line.
- frame_w, output, CW+1, active width of the last completed frame.
- frame_h, output, CW+1, active line count of the last completed frame.
- locked, output, 1, last completed frame matched EXP_H x EXP_V with no err_line.

Behaviour:
- Reset (async, rstn low): all outputs 0; state = SEARCH; all counters 0. frame_w and frame_h read 0 until the first frame completes.
- Pipeline:
  - Stage 1 registers de_in/rgb_in every cycle.
  - Stage 2 drives the outputs.
  - Latency is exactly 2 clocks from the input sample to pix_valid/pix_data.
  - eol is asserted on a stage-2 pixel whose stage-1 successor has DE=0.
- Gap counter:
  - 16-bit; counts consecutive stage-1 DE-low cycles.
  - Saturates at VGAP_MIN; clears on DE=1.
  - "vgap" is true when the counter equals VGAP_MIN.
- FSM states:
  - SEARCH: pix_valid, sof, eol and err_line are forced to 0. On vgap, go to ARMED. DE activity without a prior vgap is ignored.
  - ARMED: on a stage-1 DE rise, go to ACTIVE. This pixel is output with sof=1, pix_x=0, pix_y=0.
  - ACTIVE: each DE rise starts a new line with pix_y+1 and pix_x=0. pix_x increments on every DE=1 pixel.
- Frame end (vgap reached while ACTIVE):
  - frame_w takes the first line's length; frame_h takes the line count.
  - locked updates: set if frame_w==EXP_H, frame_h==EXP_V and no err_line occurred in the frame; otherwise cleared.
  - Go to ARMED.
- Line length:
  - Length = pix_x+1 at eol.
  - Line 0 sets the reference width.
  - Any later line whose length differs from the reference pulses err_line.
  - err_line does not break the frame; coordinate counting continues.
- Saturation:
  - pix_x saturates at 2^CW-1 and does not wrap. A line exceeding 2^CW pixels pulses err_line at eol, and its length is reported as 2^CW.
  - pix_y saturates at 2^CW-1; frame_h saturates at 2^CW.
- Single-pixel line (DE high for 1 cycle): sof (if first line) and eol are asserted on the same cycle, with pix_x=0.
- DE rising while the gap counter is below VGAP_MIN is always treated as a new line, never as a new frame.
- A frame never completed (stream stops mid-frame): frame_w, frame_h and locked hold their previous values until a vgap arrives.
- Reset asserted mid-frame: returns to SEARCH immediately. The receiver re-locks only after a full vgap followed by a DE rise.

Test Plan:
- Params EXP_H=8, EXP_V=4, VGAP_MIN=20. Drive a 30-cycle DE-low gap, then 4 lines of 8 pixels (hblank 5) with rgb = {y,x} pattern, then a 30-cycle gap.
  - Expect sof once at (0,0), 2 clocks after the first DE.
  - Expect 4 eol pulses at pix_x=7.
  - Expect frame_w=8, frame_h=4, locked=1.
  - Expect pix_data to match the pattern.
- Same stream without the initial gap → no pix_valid during the first frame. Output starts only after the first vgap; locked goes to 1 after the second frame.
- Line 2 of 9 pixels → err_line coincident with that line's eol. At frame end: frame_w=8, frame_h=4, locked=0. The next clean frame sets locked=1.
- A 19-cycle DE-low gap between lines (below VGAP_MIN) → treated as a line gap: pix_y continues 0..7 over 8 lines, and frame_h=8.
- Pulse rstn low during line 2, then release → all outputs 0 immediately, state SEARCH, no output until a vgap plus DE rise. frame_w and frame_h read 0 until the next completed frame.
- A 1-pixel line, and a line of 1030 pixels at CW=10:
  - 1-pixel line: sof and eol on the same cycle.
  - 1030-pixel line: pix_x holds at 1023 and err_line is asserted at eol.
